// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type, data width and line levels
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam int DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP = 1'b1;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter that ticks on its terminal count
module uart_baud_gen #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] r_cnt;
    assign o_tick = i_enable && (r_cnt == W'(CLK_DIV - 1));
    always_ff @(posedge clk)
        if (rst || i_clear) r_cnt <= '0;
        else if (i_enable) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: ready/valid byte in, 8N1/8N2 serial out; define UART_TX_PARITY_EN to add an even parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 868,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy
);
`ifdef UART_TX_PARITY_EN
    localparam uart_tx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_tx_state_t AFTER_DATA = STOP;
`endif
    uart_tx_state_t r_state, w_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0] r_bit_idx;
    logic r_stop_idx, r_txd, w_tick, w_hs, w_last_stop, w_txd_next, w_tail_bit;
`ifdef UART_TX_PARITY_EN
    logic r_parity;
`endif

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk(clk),
        .rst(rst),
        .i_clear(w_next != r_state),
        .i_enable(r_state != IDLE),
        .o_tick(w_tick)
    );

    always_comb begin
        w_last_stop = (r_state == STOP) && (r_stop_idx == 1'(STOP_BITS - 1)) && w_tick;
        tx_ready = !rst && ((r_state == IDLE) || w_last_stop);
        w_hs = tx_valid && tx_ready;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hs ? START : IDLE;
            START:   w_next = w_tick ? DATA : START;
            DATA:    w_next = (w_tick && r_bit_idx == 3'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
            PARITY:  w_next = w_tick ? STOP : PARITY;
`endif
            STOP:    w_next = w_last_stop ? (w_hs ? START : IDLE) : STOP;
            default: w_next = IDLE;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    assign w_tail_bit = (r_state == PARITY) ? r_parity : LINE_STOP;
`else
    assign w_tail_bit = LINE_STOP;
`endif
    // txd is registered from the current state, so the line lags the FSM by one clock
    assign w_txd_next = (r_state == IDLE) ? LINE_IDLE :
                        (r_state == START) ? LINE_START :
                        (r_state == DATA) ? r_shift[0] : w_tail_bit;
    assign txd = r_txd;
    assign tx_busy = !rst && (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_txd <= LINE_IDLE;
            r_shift <= '0;
            r_bit_idx <= '0;
            r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_txd <= w_txd_next;
            r_shift <= w_hs ? tx_data : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
            r_bit_idx <= (r_state == DATA) ? r_bit_idx + 3'(w_tick) : 3'd0;
            r_stop_idx <= (r_state == STOP && !w_last_stop) ? r_stop_idx ^ w_tick : 1'b0;
`ifdef UART_TX_PARITY_EN
            if (w_hs) r_parity <= ^tx_data;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a per-cycle line-level scoreboard for 1- and 2-stop-bit transmitters
module tb_uart_tx;
    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] d1 = 8'h00, d2 = 8'h00;
    logic v1 = 1'b0, v2 = 1'b0;
    logic rdy1, txd1, bsy1, rdy2, txd2, bsy2;
    int n_run = 0, n_fail = 0;
    int cyc = 0, hs_prev1 = 0, hs_gap1 = 0;
    bit chk_on = 1'b0;
    logic q1[$];
    logic q2[$];
    logic [12:0] f1, f2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_DIV(DIV), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
        .tx_ready(rdy1), .txd(txd1), .tx_busy(bsy1)
    );
    uart_tx #(.CLK_DIV(DIV), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2),
        .tx_ready(rdy2), .txd(txd2), .tx_busy(bsy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] frame(input logic [7:0] b);
        logic [12:0] f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (PB == 1) f[9] = ^b;
        return f;
    endfunction

    // expected line level per clock; empty queue means idle-high
    always @(negedge clk) if (chk_on) begin
        chk("txd1", 32'(txd1), 32'(q1.size() != 0 ? q1.pop_front() : 1'b1));
        if (rst) q1.delete();
        else if (v1 && rdy1) begin
            hs_gap1 = cyc - hs_prev1;
            hs_prev1 = cyc;
            f1 = frame(d1);
            if (q1.size() == 0) q1.push_back(1'b1);
            for (int i = 0; i < 10 + PB; i++)
                for (int j = 0; j < DIV; j++) q1.push_back(f1[i]);
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("txd2", 32'(txd2), 32'(q2.size() != 0 ? q2.pop_front() : 1'b1));
        if (rst) q2.delete();
        else if (v2 && rdy2) begin
            f2 = frame(d2);
            if (q2.size() == 0) q2.push_back(1'b1);
            for (int i = 0; i < 11 + PB; i++)
                for (int j = 0; j < DIV; j++) q2.push_back(f2[i]);
        end
    end

    task automatic send(input int w, input logic [7:0] b, input bit hold);
        int n = 0;
        @(posedge clk); #1;
        if (w == 0) begin v1 = 1'b1; d1 = b; end
        else begin v2 = 1'b1; d2 = b; end
        @(negedge clk);
        while (!(w == 0 ? rdy1 : rdy2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(w == 0 ? rdy1 : rdy2), 32'd1);
        @(posedge clk); #1;
        if (!hold) begin
            if (w == 0) v1 = 1'b0;
            else v2 = 1'b0;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, r;
        v1 = 1'b1;
        d1 = 8'hAA;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_txd", 32'(txd1), 32'd1);
            chk("rst_ready", 32'(rdy1), 32'd0);
            chk("rst_busy", 32'(bsy1), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        v1 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(rdy1), 32'd1);
        chk("busy_after_rst", 32'(bsy1), 32'd0);

        send(0, 8'h55, 1'b0);
        @(negedge clk);
        chk("lat_hold", 32'(txd1), 32'd1);
        c = int'(bsy1);
        @(negedge clk);
        chk("lat_fall", 32'(txd1), 32'd0);
        c += int'(bsy1);
        repeat (58) begin
            @(negedge clk);
            c += int'(bsy1);
        end
        chk("busy_len", 32'(c), 32'(10 * DIV + PB * DIV));

        send(0, 8'hA3, 1'b1);
        send(0, 8'h0F, 1'b0);
        chk("b2b_gap", 32'(hs_gap1), 32'((10 + PB) * DIV));
        r = 0;
        repeat ((10 + PB) * DIV) begin
            @(negedge clk);
            r += int'(rdy1);
        end
        chk("ready_pulses", 32'(r), 32'd1);
        repeat (5) @(negedge clk);

        send(0, 8'h12, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
            d1 = 8'($urandom);
        end
        send(0, 8'hFF, 1'b0);
        chk("bp_gap", 32'(hs_gap1), 32'((10 + PB) * DIV));
        repeat (50) @(negedge clk);

        send(0, 8'h00, 1'b0);
        repeat (18) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(rdy1), 32'd0);
        chk("midrst_busy", 32'(bsy1), 32'd0);
        @(negedge clk);
        chk("midrst_line", 32'(txd1), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(rdy1), 32'd1);
        chk("post_rst_busy", 32'(bsy1), 32'd0);
        send(0, 8'h81, 1'b0);
        repeat (50) @(negedge clk);

        send(1, 8'h07, 1'b0);
        c = 0;
        repeat (60) begin
            @(negedge clk);
            c += int'(bsy2);
        end
        chk("busy2_len", 32'(c), 32'((11 + PB) * DIV));
        repeat (5) @(negedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter directly downstream of sram_uart_lite.
- Consumes the byte stream on tx_data/tx_valid/tx_ready and drives the board TX pin as 8N1 (or 8N2) asynchronous frames.
- Replaces the constant tx_ready=1 tie-off in cpu_top, so CPU stores to the UART register are back-pressured at the real line rate.
- Instantiated in cpu_top on the same single clock.

Parameters:
- CLK_DIV, 868, clock cycles per bit (legal range ≥2; 868 gives 115200 baud at 100 MHz).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  8  byte to send; sampled on handshake.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte this cycle.
- txd  output  1  serial line, idle high, registered.
- tx_busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Handshake: a byte transfers when tx_valid && tx_ready at a rising edge. tx_data is captured into a shift register. Upstream must hold tx_data stable while tx_valid=1 && !tx_ready.
- tx_ready=1 in IDLE, and also during the final clock of the final stop bit (zero-gap back-to-back). tx_ready=0 at all other times and whenever rst=1.
- State machine: IDLE, START, DATA, PARITY (only with the option), STOP.
  - IDLE→START on handshake.
  - START→DATA after CLK_DIV cycles.
  - DATA→STOP (or →PARITY) after 8 bits.
  - PARITY→STOP after CLK_DIV cycles.
  - STOP→IDLE after STOP_BITS*CLK_DIV cycles, or STOP→START if a handshake occurs in its last cycle.
- Bit order: txd=0 for START, then data LSB first, then (optional parity), then 1 for STOP. Each bit is held exactly CLK_DIV cycles.
- Latency: txd falls on the first clock edge after the handshake edge, i.e. one cycle after acceptance.
- Frame length: (10 + STOP_BITS - 1 [+1 parity]) * CLK_DIV cycles.
- Counters:
  - Baud counter is $clog2(CLK_DIV) bits wide. It counts 0..CLK_DIV-1, wraps to 0 at terminal count, and resets to 0 on every state entry.
  - Bit index is 3 bits, 0..7.
  - Stop-bit index is 1 bit.
- Reset (any cycle, including mid-frame): state=IDLE, txd=1, tx_busy=0, counters=0, shift register=0. A frame in flight is truncated and the line returns high immediately. No byte is accepted in the reset cycle.
- tx_valid deasserted in IDLE: txd stays 1 indefinitely and no counter runs.
- tx_data changes while not handshaking: ignored.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state after DATA transmits even parity (XOR of the 8 data bits) for CLK_DIV cycles. The frame grows by one bit.
- Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Decomposition:
- Package uart_pkg:
  - state enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - localparam DATA_BITS=8.
  - localparams for idle/start/stop line levels.
- One sub-module, uart_baud_gen:
  - Parameterised by CLK_DIV.
  - Inputs clear/enable; output tick on the terminal count.
  - Reused later by a uart_rx.

Test Plan:
- Reset behaviour: CLK_DIV=4; hold rst 3 cycles with tx_valid=1 → txd=1, tx_ready=0, tx_busy=0 throughout. After release, tx_ready=1 in the first cycle.
- Single byte: send 0x55 → txd pattern 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles. txd falls 1 cycle after the handshake. tx_busy is high for 40 cycles.
- Back-to-back: tx_valid held with 0xA3 then 0x0F → the second start bit begins the cycle immediately after the first stop bit (no idle-high gap). tx_ready pulses exactly once per frame, in the last stop cycle.
- Back-pressure: assert tx_valid with 0xFF mid-frame → no acceptance until the last stop cycle. tx_data changes during the wait are ignored until the handshake.
- Mid-frame reset: assert rst during data bit 3 of 0x00 → txd=1 on the next cycle. After release, a new byte 0x81 transmits a clean full frame.
- STOP_BITS=2 and UART_TX_PARITY_EN: send 0x07 → start, 1,1,1,0,0,0,0,0, parity=1, stop, stop = 12 bits × CLK_DIV cycles.
